// File: rtl/pc_fetch_sequencer.sv
// Fetch PC owner: issues one outstanding fetch at a time, arbitrates trap/mret/branch
// redirects onto the PC and tags each request with an epoch so that killed responses are dropped.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_BOOT  | first cycle after reset, redirects ignored
// S_ISSUE | fetch_valid held with a stable pc/epoch until accepted
// S_WAIT  | one live request outstanding, waiting for its response
// S_REDIR | idle cycle after a redirect so valid never sees an address change
// S_DRAIN | one killed request outstanding, its response is dropped
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_VEC = 32'h8000_0000,
    parameter int          EPOCH_W   = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic               fetch_valid,
    input  logic               fetch_ready,
    output logic [31:0]        fetch_pc,
    output logic [EPOCH_W-1:0] fetch_epoch,
    input  logic               inst_valid,
    input  logic [EPOCH_W-1:0] inst_epoch,
    input  logic               trap_valid,
    input  logic [31:0]        trap_target,
    input  logic               mret_valid,
    input  logic [31:0]        mret_target,
    input  logic               br_valid,
    input  logic [31:0]        br_target,
    output logic               flush,
    output logic [31:0]        pc
);

    typedef enum logic [2:0] {
        S_BOOT  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_REDIR = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;
    logic               flush_q, flush_d;

    logic               redir;
    logic [31:0]        tgt;
    logic               take;

    // Fixed priority: trap > mret > branch.
    always_comb begin
        redir = trap_valid | mret_valid | br_valid;
        tgt   = br_target;
        if (trap_valid) begin
            tgt = trap_target;
        end else if (mret_valid) begin
            tgt = mret_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_VEC;
            epoch_q <= '0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epoch_q <= epoch_d;
            flush_q <= flush_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epoch_d = epoch_q;
        flush_d = 1'b0;
        take    = 1'b0;

        case (state_q)
            S_BOOT: begin
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (fetch_ready) begin
                    // An accepted request with a simultaneous redirect is already stale.
                    state_d = redir ? S_DRAIN : S_WAIT;
                    take    = redir;
                end else if (redir) begin
                    state_d = S_REDIR;
                    take    = 1'b1;
                end
            end
            S_REDIR: begin
                if (redir) begin
                    state_d = S_REDIR;
                    take    = 1'b1;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_WAIT: begin
                if (inst_valid) begin
                    state_d = S_ISSUE;
                    take    = redir;
                    if (!redir && (inst_epoch == epoch_q)) begin
                        pc_d = pc_q + 32'd4;
                    end
                end else if (redir) begin
                    state_d = S_DRAIN;
                    take    = 1'b1;
                end
            end
            S_DRAIN: begin
                if (inst_valid) begin
                    state_d = S_ISSUE;
                    take    = redir;
                end else if (redir) begin
                    state_d = S_DRAIN;
                    take    = 1'b1;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase

        if (take) begin
            pc_d    = tgt;
            epoch_d = epoch_q + EPOCH_W'(1);
            flush_d = 1'b1;
        end
    end

    assign fetch_valid = (state_q == S_ISSUE);
    assign fetch_pc    = pc_q;
    assign fetch_epoch = epoch_q;
    assign pc          = pc_q;
    assign flush       = flush_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: directed scenarios with literal expectations, then random
// traffic against a request-level model (pc, epoch, in-flight/killed request, idle-after-redirect).
module tb_pc_fetch_sequencer;

    localparam logic [31:0] RV = 32'h8000_0000;

    logic        clk;
    logic        rst;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_pc;
    logic [1:0]  fetch_epoch;
    logic        inst_valid;
    logic [1:0]  inst_epoch;
    logic        trap_valid;
    logic [31:0] trap_target;
    logic        mret_valid;
    logic [31:0] mret_target;
    logic        br_valid;
    logic [31:0] br_target;
    logic        flush;
    logic [31:0] pc;

    pc_fetch_sequencer #(.RESET_VEC(RV), .EPOCH_W(2)) dut (
        .clk(clk), .rst(rst),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .fetch_pc(fetch_pc), .fetch_epoch(fetch_epoch),
        .inst_valid(inst_valid), .inst_epoch(inst_epoch),
        .trap_valid(trap_valid), .trap_target(trap_target),
        .mret_valid(mret_valid), .mret_target(mret_target),
        .br_valid(br_valid), .br_target(br_target),
        .flush(flush), .pc(pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Request-level model state.
    logic [31:0] m_pc;
    logic [1:0]  m_epoch;
    logic        m_boot, m_inflight, m_stale, m_hold, m_flush;
    logic [31:0] n_pc;
    logic [1:0]  n_epoch;
    logic        n_boot, n_inflight, n_stale, n_hold, n_flush;
    logic        m_fv;
    assign m_fv = !m_boot && !m_inflight && !m_hold;

    // Simple IFU: answers each accepted request after 1..4 cycles, echoing its epoch.
    logic        ifu_auto;
    logic        ifu_pend;
    int          ifu_cnt;
    logic [1:0]  ifu_ep;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("fetch_valid", {31'b0, fetch_valid}, {31'b0, m_fv});
        chk("fetch_pc", fetch_pc, m_pc);
        chk("pc", pc, m_pc);
        chk("fetch_epoch", {30'b0, fetch_epoch}, {30'b0, m_epoch});
        chk("flush", {31'b0, flush}, {31'b0, m_flush});
    end

    task automatic model_reset();
        m_pc = RV; m_epoch = 2'd0; m_boot = 1'b1;
        m_inflight = 1'b0; m_stale = 1'b0; m_hold = 1'b0; m_flush = 1'b0;
    endtask

    task automatic model_next();
        logic        rd, acc, resp;
        logic [31:0] t;
        n_pc = m_pc; n_epoch = m_epoch; n_boot = 1'b0;
        n_inflight = m_inflight; n_stale = m_stale; n_hold = 1'b0; n_flush = 1'b0;
        if (!m_boot) begin
            rd   = trap_valid || mret_valid || br_valid;
            t    = trap_valid ? trap_target : (mret_valid ? mret_target : br_target);
            acc  = m_fv && fetch_ready;
            resp = inst_valid && m_inflight;
            if (resp) begin
                if (!m_stale && inst_epoch == m_epoch && !rd) n_pc = m_pc + 32'd4;
                n_inflight = 1'b0;
            end
            if (acc) begin
                n_inflight = 1'b1;
                n_stale    = 1'b0;
            end
            if (rd) begin
                n_pc    = t;
                n_epoch = m_epoch + 2'd1;
                n_flush = 1'b1;
                if (n_inflight) n_stale = 1'b1;
                n_hold  = !n_inflight && !resp;
            end
        end
    endtask

    // Called at posedge+1; drives one cycle of inputs and advances the model across the edge.
    task automatic step(input logic fr, input logic tv, input logic [31:0] tt,
                        input logic mv, input logic [31:0] mt,
                        input logic bv, input logic [31:0] bt, input logic iv);
        fetch_ready = fr;
        trap_valid = tv; trap_target = tt;
        mret_valid = mv; mret_target = mt;
        br_valid = bv; br_target = bt;
        if (ifu_auto) begin
            if (ifu_pend && ifu_cnt == 0) begin
                inst_valid = 1'b1; inst_epoch = ifu_ep; ifu_pend = 1'b0;
            end else begin
                inst_valid = 1'b0;
                if (ifu_pend) ifu_cnt = ifu_cnt - 1;
            end
        end else begin
            inst_valid = iv; inst_epoch = ifu_ep;
        end
        #1;
        if (fetch_valid && fetch_ready) begin
            ifu_pend = 1'b1; ifu_cnt = $urandom_range(0, 3); ifu_ep = fetch_epoch;
        end
        model_next();
        @(posedge clk);
        m_pc = n_pc; m_epoch = n_epoch; m_boot = n_boot; m_inflight = n_inflight;
        m_stale = n_stale; m_hold = n_hold; m_flush = n_flush;
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        model_reset();
        ifu_pend = 1'b0; ifu_cnt = 0;
        fetch_ready = 1'b0; inst_valid = 1'b0;
        trap_valid = 1'b0; mret_valid = 1'b0; br_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        fetch_ready = 1'b0; inst_valid = 1'b0; inst_epoch = 2'd0;
        trap_valid = 1'b0; trap_target = 32'h0;
        mret_valid = 1'b0; mret_target = 32'h0;
        br_valid = 1'b0; br_target = 32'h0;
        ifu_auto = 1'b0; ifu_pend = 1'b0; ifu_cnt = 0; ifu_ep = 2'd0;
        model_reset();
        @(posedge clk);
        #1;
        reset_dut();
        chk("boot_valid", {31'b0, fetch_valid}, 32'd0);
        chk("boot_pc", pc, RV);

        // Sequential fetch, response two cycles after each accept.
        idle();
        chk("issue0_valid", {31'b0, fetch_valid}, 32'd1);
        chk("issue0_pc", fetch_pc, 32'h8000_0000);
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
            chk("wait_valid", {31'b0, fetch_valid}, 32'd0);
            idle();
            step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        end
        chk("seq_pc", fetch_pc, 32'h8000_0008);
        chk("seq_epoch", {30'b0, fetch_epoch}, 32'd0);
        chk("seq_flush", {31'b0, flush}, 32'd0);
        chk("model_seq_pc", m_pc, 32'h8000_0008);

        // Backpressure holds request stable.
        for (int k = 0; k < 5; k++) begin
            idle();
            chk("hold_valid", {31'b0, fetch_valid}, 32'd1);
            chk("hold_pc", fetch_pc, 32'h8000_0008);
        end
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("hold_accept", {31'b0, fetch_valid}, 32'd0);

        // Branch in WAIT without response -> DRAIN, stale response dropped.
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h8000_0100, 1'b0);
        chk("br_flush", {31'b0, flush}, 32'd1);
        chk("br_epoch", {30'b0, fetch_epoch}, 32'd1);
        chk("br_pc", pc, 32'h8000_0100);
        chk("model_br_pc", m_pc, 32'h8000_0100);
        idle();
        chk("drain_valid", {31'b0, fetch_valid}, 32'd0);
        chk("drain_flush", {31'b0, flush}, 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("drain_done_valid", {31'b0, fetch_valid}, 32'd1);
        chk("drain_done_pc", fetch_pc, 32'h8000_0100);

        // Simultaneous redirects in ISSUE without handshake: trap wins, one idle cycle.
        step(1'b0, 1'b1, 32'h8000_0200, 1'b1, 32'h8000_0300, 1'b1, 32'h8000_0400, 1'b0);
        chk("prio_pc", pc, 32'h8000_0200);
        chk("prio_valid", {31'b0, fetch_valid}, 32'd0);
        chk("prio_epoch", {30'b0, fetch_epoch}, 32'd2);
        idle();
        chk("prio_reissue_valid", {31'b0, fetch_valid}, 32'd1);
        chk("prio_reissue_pc", fetch_pc, 32'h8000_0200);

        // Response and branch together in WAIT -> ISSUE at the target.
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h8000_1000, 1'b1);
        chk("resp_br_pc", pc, 32'h8000_1000);
        chk("resp_br_valid", {31'b0, fetch_valid}, 32'd1);
        chk("resp_br_epoch", {30'b0, fetch_epoch}, 32'd3);

        // Epoch wraps 3 -> 0 -> 1.
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h8000_2000, 1'b0);
        chk("wrap_epoch0", {30'b0, fetch_epoch}, 32'd0);
        chk("model_wrap_epoch0", {30'b0, m_epoch}, 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_3000, 1'b0, 32'h0, 1'b0);
        chk("wrap_epoch1", {30'b0, fetch_epoch}, 32'd1);
        chk("redir_again_valid", {31'b0, fetch_valid}, 32'd0);
        idle();
        chk("wrap_reissue_pc", fetch_pc, 32'h8000_3000);

        // Reset while draining.
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h8000_4000, 1'b0);
        chk("pre_rst_valid", {31'b0, fetch_valid}, 32'd0);
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_pc", pc, 32'h8000_0000);
        chk("rst_epoch", {30'b0, fetch_epoch}, 32'd0);
        chk("rst_valid", {31'b0, fetch_valid}, 32'd0);
        chk("rst_flush", {31'b0, flush}, 32'd0);
        @(posedge clk);
        #1;
        reset_dut();

        // Random traffic against the model.
        ifu_auto = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 499) == 0) begin
                reset_dut();
            end else begin
                step($urandom_range(0, 9) < 7,
                     $urandom_range(0, 19) == 0, $urandom,
                     $urandom_range(0, 19) == 0, $urandom,
                     $urandom_range(0, 9) == 0, $urandom,
                     1'b0);
            end
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
